byte_port_initiator: RTL and testbench
======================================

Name: byte_port_initiator

Overview:
- Initiator for the simple byte-wide strobe/ack port exposed by our DUT-side blocks: wr/rd strobes, 8-bit write data, 8-bit read data, single-bit done/ack.
- Accepts one command at a time from an upstream valid/ready interface and drives a one-cycle strobe plus write data to the slave.
- Waits for the slave ack with a timeout, then returns read data and an error flag on a valid/ready response interface.
- Sits between test/sequencer logic or a host bridge and any block implementing the responder side of this port.

Parameters:
DATA_W, 8, width of command write data, slave data buses and response read data
TIMEOUT_CYC, 16, max cycles spent in WAIT_ACK before abandoning a transaction (legal range 1..255)
CNT_W, 16, width of the completed-transaction counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  upstream command valid
cmd_ready  output  1  block can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_wdata  input  DATA_W  write data
rsp_valid  output  1  response valid
rsp_ready  input  1  upstream accepts response
rsp_rdata  output  DATA_W  read data (0 for writes and errors)
rsp_err  output  1  transaction timed out
slv_wr  output  1  one-cycle write strobe to slave
slv_rd  output  1  one-cycle read strobe to slave
slv_wdata  output  DATA_W  write data to slave
slv_rdata  input  DATA_W  read data from slave
slv_ack  input  1  slave done/ack
busy  output  1  transaction in flight (state != IDLE)
stray_ack  output  1  sticky: ack seen outside WAIT_ACK
txn_count  output  CNT_W  completed responses, wraps

Behaviour:
- Reset: rst high forces every output to 0 immediately (async), state to IDLE, and clears txn_count and stray_ack. cmd_ready rises on the first clock edge after rst deasserts.
- Any in-flight transaction is dropped on reset, with no response and no count.
- All outputs are registered.
- FSM states: IDLE, STROBE, WAIT_ACK, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch cmd_write and cmd_wdata, then go to STROBE.
- STROBE:
  - Exactly one cycle.
  - slv_wr=cmd_write or slv_rd=!cmd_write; never both.
  - slv_wdata = latched data; it holds until the next command and is 0 after reset.
  - slv_ack during STROBE is ignored and does not set stray_ack.
  - Go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK:
  - Sample slv_ack every cycle.
  - On ack: capture slv_rdata for a read (0 for a write), set rsp_err=0, go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYC, set rsp_err=1 and rsp_rdata=0, then go to RESP.
  - Ack in the same cycle the counter hits TIMEOUT_CYC counts as success (ack wins).
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are stable until handshake.
  - On rsp_ready: txn_count+1 (wrapping at 2^CNT_W), go to IDLE.
  - rsp_valid falls the cycle after the handshake. There is no combinational ready-to-valid path.
- Latency: command accepted at edge N -> strobe in cycle N+1 -> earliest ack sampled in cycle N+2 -> rsp_valid in cycle N+3.
- Back-to-back throughput: one command per 4 cycles minimum.
- stray_ack: set when slv_ack=1 in IDLE or RESP (for example, a late ack after a timeout). Sticky until rst. It has no other effect.
- cmd_* inputs are ignored while cmd_ready=0.

Decomposition:
- Package byte_port_pkg holds:
  - state enum typedef (IDLE, STROBE, WAIT_ACK, RESP);
  - DATA_W default constant;
  - response struct {rdata, err}.
- Responder-side blocks share this package.
- One natural sub-module: byte_port_timeout, a loadable counter with clear/enable/expired flag, sized to clog2(TIMEOUT_CYC+1). All else lives in the top module.

Test Plan:
- Reset mid-operation: assert rst during WAIT_ACK -> all outputs 0 asynchronously; no response and txn_count=0 after release; cmd_ready=1 after the first edge.
- Write: cmd write 0xA5, slave acks 2 cycles after the strobe -> slv_wr high exactly 1 cycle with slv_wdata=0xA5, slv_rd never high; response rdata=0x00, err=0; txn_count=1.
- Read: cmd read, slave drives slv_rdata=0x3C with ack on the first WAIT_ACK cycle -> rsp_valid at accept+3, rdata=0x3C, err=0.
- Timeout and late ack (TIMEOUT_CYC=16):
  - No ack -> rsp_err=1, rdata=0 after 16 WAIT_ACK cycles.
  - An ack arriving while in RESP -> stray_ack=1 and stays high.
- Timeout boundary: ack on exactly the 16th WAIT_ACK cycle -> err=0 with valid data; ack on the 17th -> err=1 and stray_ack=1.
- Backpressure and wrap:
  - Hold rsp_ready=0 for 10 cycles -> response stable, cmd_ready=0, no slave strobes.
  - With CNT_W=4, 17 transactions -> txn_count=1.

Source files
------------

// File: rtl/byte_port_pkg.sv
// Shared types for the byte-wide strobe/ack port: initiator FSM states and
// the response payload used by both initiator and responder-side blocks.
package byte_port_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STROBE   = 2'd1,
    WAIT_ACK = 2'd2,
    RESP     = 2'd3
  } bp_state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] rdata;
    logic                  err;
  } bp_rsp_t;

endpackage

// File: rtl/byte_port_timeout.sv
// Saturating cycle counter for the ack wait; expired_o flags the last
// permitted wait cycle so the caller can give up at the following edge.
module byte_port_timeout #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/byte_port_initiator.sv
// Initiator for the byte-wide strobe/ack port: one command at a time,
// one-cycle strobe, ack wait with timeout, registered valid/ready response.
module byte_port_initiator
  import byte_port_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              slv_wr,
  output logic              slv_rd,
  output logic [DATA_W-1:0] slv_wdata,
  input  logic [DATA_W-1:0] slv_rdata,
  input  logic              slv_ack,
  output logic              busy,
  output logic              stray_ack,
  output logic [CNT_W-1:0]  txn_count
);

  bp_state_e         state_q;
  logic              write_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              slv_wr_q;
  logic              slv_rd_q;
  logic [DATA_W-1:0] slv_wdata_q;
  logic              busy_q;
  logic              stray_ack_q;
  logic [CNT_W-1:0]  txn_count_q;
  logic              tmo_expired;

  byte_port_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == STROBE),
    .en_i      (state_q == WAIT_ACK),
    .expired_o (tmo_expired)
  );

  // Transaction FSM with all outputs held in registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
      slv_wr_q    <= 1'b0;
      slv_rd_q    <= 1'b0;
      slv_wdata_q <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
      stray_ack_q <= 1'b0;
      txn_count_q <= {CNT_W{1'b0}};
    end else begin
      // Acks outside STROBE/WAIT_ACK are only recorded, never acted upon.
      if (slv_ack && ((state_q == IDLE) || (state_q == RESP))) begin
        stray_ack_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            write_q     <= cmd_write;
            slv_wdata_q <= cmd_wdata;
            slv_wr_q    <= cmd_write;
            slv_rd_q    <= !cmd_write;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= STROBE;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        STROBE: begin
          slv_wr_q <= 1'b0;
          slv_rd_q <= 1'b0;
          state_q  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (slv_ack) begin
            rsp_rdata_q <= write_q ? {DATA_W{1'b0}} : slv_rdata;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (tmo_expired) begin
            rsp_rdata_q <= {DATA_W{1'b0}};
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            txn_count_q <= txn_count_q + CNT_W'(1);
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign slv_wr    = slv_wr_q;
  assign slv_rd    = slv_rd_q;
  assign slv_wdata = slv_wdata_q;
  assign busy      = busy_q;
  assign stray_ack = stray_ack_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_byte_port_initiator.sv
// Directed bench for byte_port_initiator: expected responses are queued at
// issue time and a negedge monitor compares them at each handshake.
module tb_byte_port_initiator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       slv_wr;
  logic       slv_rd;
  logic [7:0] slv_wdata;
  logic [7:0] slv_rdata = 8'h00;
  logic       slv_ack = 1'b0;
  logic       busy;
  logic       stray_ack;
  logic [3:0] txn_count;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int both_cnt = 0;
  logic [7:0] wdata_seen = 8'h00;
  logic [8:0] exp_q[$];
  int exp_cnt = 0;

  byte_port_initiator #(
    .DATA_W      (8),
    .TIMEOUT_CYC (16),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .slv_wr    (slv_wr),
    .slv_rd    (slv_rd),
    .slv_wdata (slv_wdata),
    .slv_rdata (slv_rdata),
    .slv_ack   (slv_ack),
    .busy      (busy),
    .stray_ack (stray_ack),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: one pop per valid&&ready handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e[7:0]});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[8]});
      end
    end
  end

  // Strobe monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (slv_wr) begin
        wr_cnt++;
        wdata_seen = slv_wdata;
      end
      if (slv_rd) rd_cnt++;
      if (slv_wr && slv_rd) both_cnt++;
    end
  end

  task automatic do_cmd(input logic w, input logic [7:0] d);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic ack_after(input int k, input logic [7:0] d);
    repeat (k) tick();
    slv_ack   = 1'b1;
    slv_rdata = d;
    tick();
    slv_ack   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("idle_wait", {31'd0, busy}, 32'd0);
    exp_cnt++;
    chk("txn_count", {28'd0, txn_count}, {28'd0, exp_cnt[3:0]});
  endtask

  initial begin
    int wr0;
    int rd0;
    int n;
    #2;
    chk("reset_outputs", {29'd0, cmd_ready, rsp_valid, busy}, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // Reset during WAIT_ACK: no response, no count.
    do_cmd(1'b1, 8'h99);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_reset_all", {21'd0, cmd_ready, rsp_valid, rsp_err, slv_wr, slv_rd, busy, stray_ack, txn_count},
        32'd0);
    chk("async_reset_wdata", {24'd0, slv_wdata, rsp_rdata[7:0]} >> 8, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("ready_before_edge", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("ready_first_edge", {31'd0, cmd_ready}, 32'd1);
    chk("count_after_reset", {28'd0, txn_count}, 32'd0);
    chk("no_rsp_after_reset", {31'd0, rsp_valid}, 32'd0);

    // Write 0xA5, ack two cycles after the strobe.
    wr0 = wr_cnt; rd0 = rd_cnt;
    exp_q.push_back({1'b0, 8'h00});
    do_cmd(1'b1, 8'hA5);
    ack_after(2, 8'hEE);
    wait_idle();
    chk("wr_strobes", wr_cnt - wr0, 32'd1);
    chk("wr_no_rd", rd_cnt - rd0, 32'd0);
    chk("wr_wdata", {24'd0, wdata_seen}, 32'h0000_00A5);

    // Read 0x3C, ack on first WAIT_ACK cycle, valid at accept+3.
    wr0 = wr_cnt; rd0 = rd_cnt;
    exp_q.push_back({1'b0, 8'h3C});
    do_cmd(1'b0, 8'h00);
    tick();
    chk("rd_wait_novalid", {31'd0, rsp_valid}, 32'd0);
    slv_ack = 1'b1; slv_rdata = 8'h3C;
    tick();
    slv_ack = 1'b0;
    chk("rd_latency", {31'd0, rsp_valid}, 32'd1);
    wait_idle();
    chk("rd_strobes", rd_cnt - rd0, 32'd1);
    chk("rd_no_wr", wr_cnt - wr0, 32'd0);

    // Ack during STROBE is ignored and not stray.
    exp_q.push_back({1'b0, 8'h00});
    do_cmd(1'b1, 8'h11);
    slv_ack = 1'b1;
    tick();
    slv_ack = 1'b0;
    ack_after(1, 8'h00);
    wait_idle();
    chk("strobe_ack_not_stray", {31'd0, stray_ack}, 32'd0);

    // Boundary: ack on 16th WAIT_ACK cycle wins.
    exp_q.push_back({1'b0, 8'h77});
    do_cmd(1'b0, 8'h00);
    ack_after(16, 8'h77);
    wait_idle();
    chk("ack16_no_stray", {31'd0, stray_ack}, 32'd0);

    // Boundary: ack on 17th cycle is too late.
    exp_q.push_back({1'b1, 8'h00});
    do_cmd(1'b0, 8'h00);
    ack_after(17, 8'h88);
    wait_idle();
    chk("ack17_stray", {31'd0, stray_ack}, 32'd1);

    // Timeout without ack, late ack while response is held.
    rsp_ready = 1'b0;
    exp_q.push_back({1'b1, 8'h00});
    do_cmd(1'b0, 8'h00);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, 32'd17);
    slv_ack = 1'b1; slv_rdata = 8'h55;
    tick();
    slv_ack = 1'b0;
    chk("late_ack_stray", {31'd0, stray_ack}, 32'd1);
    chk("late_ack_err_held", {31'd0, rsp_err}, 32'd1);
    rsp_ready = 1'b1;
    wait_idle();

    // Backpressure: response stable, commands ignored, no strobes.
    rsp_ready = 1'b0;
    wr0 = wr_cnt; rd0 = rd_cnt;
    exp_q.push_back({1'b0, 8'h5A});
    do_cmd(1'b0, 8'h00);
    ack_after(1, 8'h5A);
    slv_rdata = 8'h00;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wdata = 8'hC3;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", {24'd0, rsp_rdata}, 32'h0000_005A);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
    end
    cmd_valid = 1'b0;
    chk("bp_rd_strobes", rd_cnt - rd0, 32'd1);
    chk("bp_wr_strobes", wr_cnt - wr0, 32'd0);
    rsp_ready = 1'b1;
    wait_idle();
    chk("stray_sticky", {31'd0, stray_ack}, 32'd1);

    // Fill to 17 transactions to wrap the 4-bit counter.
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({1'b0, 8'h00});
      do_cmd(1'b1, 8'(i));
      ack_after(1, 8'hFF);
      wait_idle();
    end
    chk("count_wrap", {28'd0, txn_count}, 32'd1);
    tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("never_both_strobes", both_cnt, 32'd0);

    rst = 1'b1;
    #1;
    chk("reset_clears_stray", {31'd0, stray_ack}, 32'd0);
    chk("reset_clears_count", {28'd0, txn_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
